branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Consumes EX-stage ALU flags (Zero, sign) and the decoded branch type; decides taken/not-taken
//  (BNE uses the inverted Zero flag) and drives the PC-select mux and pipeline flushes.
//  Sits between the ALU/NotGate flag logic and the IF-stage PC mux / IF_ID, ID_EX registers.
//  Static predict-not-taken: every taken branch costs a registered redirect plus flush window.
// PARAMETERS
//  ADDR_W        32  width of PC / branch target
//  FLUSH_CYCLES  2   total cycles flush_if_id is asserted per taken branch (>=1)
//  CNT_W         16  width of the saturating statistics counters
// PORTS
//  Clk          in   1       system clock, rising edge
//  Rst          in   1       asynchronous reset, active-low
//  ex_valid     in   1       EX stage holds a valid instruction this cycle
//  ex_br_type   in   3       0 NONE,1 BEQ,2 BNE,3 BGTZ,4 BLEZ,5 BLTZ,6 BGEZ,7 J
//  alu_zero     in   1       ALU Zero flag for the EX instruction
//  alu_neg      in   1       sign bit of rs (compare-with-zero branches)
//  ex_target    in   ADDR_W  computed branch/jump target
//  stall        in   1       pipeline stall from hazard unit; freezes this block
//  pc_src       out  1       1 = PC mux selects pc_target
//  pc_target    out  ADDR_W  latched redirect address
//  flush_if_id  out  1       squash IF_ID register contents
//  flush_id_ex  out  1       squash ID_EX register contents
//  busy         out  1       redirect/flush window in progress
//  branch_cnt   out  CNT_W   resolved branches (type != NONE)
//  taken_cnt    out  CNT_W   taken branches
// BEHAVIOUR
//  Reset (Rst=0, async): state IDLE; all outputs 0, counters 0, flush counter 0. Reset
//   asserted mid-window aborts it immediately; first cycle after release is IDLE.
//  Condition: BEQ=zero; BNE=~zero; BGTZ=~zero&~neg; BLEZ=zero|neg; BLTZ=neg; BGEZ=~neg; J=1.
//  States: IDLE -> REDIRECT -> FLUSH -> IDLE; all outputs registered (1-cycle latency).
//  IDLE: on ex_valid & type!=NONE & ~stall: branch_cnt+1; if taken: taken_cnt+1,
//   pc_target<=ex_target, next REDIRECT. Not taken: stay IDLE, outputs stay 0.
//  REDIRECT (1 cycle): pc_src=1, flush_if_id=1, flush_id_ex=1, busy=1.
//   FLUSH_CYCLES==1 -> IDLE, else -> FLUSH with remaining = FLUSH_CYCLES-1.
//  FLUSH: pc_src=0, flush_if_id=1, flush_id_ex=0, busy=1; decrement; remaining==1 -> IDLE.
//  ex_valid ignored outside IDLE (those slots are squashed); not counted.
//  stall=1: state, flush counter, pc_target, counters and outputs all hold. A branch arriving
//   with stall=1 is not evaluated; it is evaluated on the first cycle stall=0.
//  Counters saturate at 2^CNT_W-1, no wrap. pc_target holds last taken target until next.
//  Illegal state encoding -> IDLE next cycle, outputs 0.
// STRUCTURE
//  Shared package branch_pkg: BR_NONE..BR_J 3-bit codes, state encodings (IDLE/REDIRECT/FLUSH).
//  Sub-module branch_cond: combinational (br_type, zero, neg) -> taken; reuses NotGate for ~zero.
//  Top holds FSM, flush down-counter, target latch, saturating counters.
// TESTING
//  BEQ, zero=1, target 0x0040_0020 -> next cycle pc_src=1, pc_target=0x0040_0020, both flushes 1;
//   then 1 cycle flush_if_id only; busy 2 cycles; taken_cnt=1, branch_cnt=1.
//  BNE with zero=1 -> no redirect, outputs 0, branch_cnt=1, taken_cnt=0; BNE zero=0 -> taken.
//  BLEZ/BGTZ/BLTZ/BGEZ over (zero,neg) in {00,01,10} -> taken matches condition table exactly.
//  Taken BEQ, stall=1 for 3 cycles during REDIRECT -> pc_src/flushes held 3 extra cycles, then
//   normal sequence; second branch presented during FLUSH ignored, counters unchanged.
//  Rst low during FLUSH -> all outputs 0 asynchronously; after release IDLE, new branch accepted.
//  CNT_W=4, 20 taken J -> taken_cnt=branch_cnt=15 (saturated); FLUSH_CYCLES=1 -> no FLUSH state.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch type codes and FSM encodings for the
// branch resolve unit and its condition decoder.
package branch_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BGTZ = 3'd3;
  localparam logic [2:0] BR_BLEZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;
  localparam logic [2:0] BR_J    = 3'd7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REDIR = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decoder: ALU flags plus branch type
// to a taken/not-taken decision.
module NotGate (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       zero,
  input  logic       neg,
  output logic       taken
);

  logic nzero;

  NotGate u_not (
    .a (zero),
    .y (nzero)
  );

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      (br_type == BR_BEQ):  taken = zero;
      (br_type == BR_BNE):  taken = nzero;
      (br_type == BR_BGTZ): taken = nzero & ~neg;
      (br_type == BR_BLEZ): taken = zero | neg;
      (br_type == BR_BLTZ): taken = neg;
      (br_type == BR_BGEZ): taken = ~neg;
      (br_type == BR_J):    taken = 1'b1;
      default:              taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: taken decision, PC redirect,
// flush window sequencing and branch statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ex_valid,
  input  logic [2:0]        ex_br_type,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              stall,
  output logic              pc_src,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              busy,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam int FW = (FLUSH_CYCLES > 1) ?
                      $clog2(FLUSH_CYCLES) + 1 : 1;
  localparam logic [FW-1:0] FRELOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0] FONE    = FW'(1);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_n;
  logic          taken;
  logic          accept;

  branch_cond u_cond (
    .br_type (ex_br_type),
    .zero    (alu_zero),
    .neg     (alu_neg),
    .taken   (taken)
  );

  assign accept = (state == S_IDLE) & ex_valid &
                  (ex_br_type != BR_NONE) & ~stall;

  always_comb begin
    state_n = S_IDLE;
    fcnt_n  = fcnt;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (accept && taken)
          state_n = S_REDIR;
      end
      (state == S_REDIR): begin
        if (FLUSH_CYCLES > 1) begin
          state_n = S_FLUSH;
          fcnt_n  = FRELOAD;
        end
      end
      (state == S_FLUSH): begin
        if (fcnt > FONE) begin
          state_n = S_FLUSH;
          fcnt_n  = fcnt - FONE;
        end else begin
          fcnt_n  = '0;
        end
      end
      default: fcnt_n = '0;
    endcase
  end

  // Outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= S_IDLE;
      fcnt        <= '0;
      pc_src      <= 1'b0;
      flush_if_id <= 1'b0;
      flush_id_ex <= 1'b0;
      busy        <= 1'b0;
    end else if (!stall) begin
      state       <= state_n;
      fcnt        <= fcnt_n;
      pc_src      <= (state_n == S_REDIR);
      flush_if_id <= (state_n == S_REDIR) |
                     (state_n == S_FLUSH);
      flush_id_ex <= (state_n == S_REDIR);
      busy        <= (state_n == S_REDIR) |
                     (state_n == S_FLUSH);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_target  <= '0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (accept) begin
      if (branch_cnt != CMAX)
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (taken) begin
        pc_target <= ex_target;
        if (taken_cnt != CMAX)
          taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit with
// three parameterizations checked against a window model.
module tb_branch_resolve_unit;

  localparam int N = 3;

  logic        Clk;
  logic        Rst;
  logic        ex_valid;
  logic [2:0]  ex_br_type;
  logic        alu_zero;
  logic        alu_neg;
  logic [31:0] ex_target;
  logic        stall;

  logic        ps_w [N];
  logic        fi_w [N];
  logic        fe_w [N];
  logic        bz_w [N];
  logic [31:0] tg_w [N];
  logic [15:0] bc_w [N];
  logic [15:0] tc_w [N];

  int checks = 0;
  int errors = 0;

  int fcy  [N] = '{2, 1, 3};
  int cmax [N] = '{65535, 15, 65535};
  int left [N];
  int mbc  [N];
  int mtc  [N];
  logic [31:0] mtg [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int FC = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    localparam int CW = (g == 1) ? 4 : 16;
    logic [CW-1:0] bc;
    logic [CW-1:0] tc;
    branch_resolve_unit #(
      .ADDR_W       (32),
      .FLUSH_CYCLES (FC),
      .CNT_W        (CW)
    ) u_dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .ex_valid    (ex_valid),
      .ex_br_type  (ex_br_type),
      .alu_zero    (alu_zero),
      .alu_neg     (alu_neg),
      .ex_target   (ex_target),
      .stall       (stall),
      .pc_src      (ps_w[g]),
      .pc_target   (tg_w[g]),
      .flush_if_id (fi_w[g]),
      .flush_id_ex (fe_w[g]),
      .busy        (bz_w[g]),
      .branch_cnt  (bc),
      .taken_cnt   (tc)
    );
    assign bc_w[g] = 16'(bc);
    assign tc_w[g] = 16'(tc);
  end

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cond(input int t, input bit z, input bit n);
    case (t)
      1: return z;
      2: return !z;
      3: return !z && !n;
      4: return z || n;
      5: return n;
      6: return !n;
      7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      mbc[i]  = 0;
      mtc[i]  = 0;
      mtg[i]  = '0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("d%0d pc_src", i), 64'(ps_w[i]),
            64'(left[i] == fcy[i]));
      check($sformatf("d%0d flush_if_id", i), 64'(fi_w[i]),
            64'(left[i] > 0));
      check($sformatf("d%0d flush_id_ex", i), 64'(fe_w[i]),
            64'(left[i] == fcy[i]));
      check($sformatf("d%0d busy", i), 64'(bz_w[i]),
            64'(left[i] > 0));
      check($sformatf("d%0d pc_target", i), 64'(tg_w[i]),
            64'(mtg[i]));
      check($sformatf("d%0d branch_cnt", i), 64'(bc_w[i]),
            64'(mbc[i]));
      check($sformatf("d%0d taken_cnt", i), 64'(tc_w[i]),
            64'(mtc[i]));
    end
  endtask

  task automatic step(input bit v, input int t, input bit z,
                      input bit n, input logic [31:0] tg,
                      input bit st);
    ex_valid   = v;
    ex_br_type = 3'(t);
    alu_zero   = z;
    alu_neg    = n;
    ex_target  = tg;
    stall      = st;
    @(posedge Clk);
    for (int i = 0; i < N; i++) begin
      if (!st) begin
        if (left[i] > 0) begin
          left[i]--;
        end else if (v && t != 0) begin
          if (mbc[i] < cmax[i]) mbc[i]++;
          if (cond(t, z, n)) begin
            if (mtc[i] < cmax[i]) mtc[i]++;
            mtg[i]  = tg;
            left[i] = fcy[i];
          end
        end
      end
    end
    #1 check_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      step(0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    Rst = 1'b0;
    ex_valid = 0; ex_br_type = 0; alu_zero = 0;
    alu_neg = 0; ex_target = 0; stall = 0;
    model_reset();
    @(posedge Clk);
    @(posedge Clk);
    #1 check_all();
    #3 Rst = 1'b1;

    // taken BEQ: redirect then one flush-only cycle on d0
    step(1, 1, 1, 0, 32'h0040_0020, 0);
    idle(4);

    // BNE not taken, then taken
    step(1, 2, 1, 0, 32'h0000_1000, 0);
    idle(1);
    step(1, 2, 0, 0, 32'h0000_2000, 0);
    idle(4);

    // compare-with-zero branches over (zero,neg)
    for (int t = 3; t <= 6; t++) begin
      for (int zn = 0; zn < 3; zn++) begin
        step(1, t, zn[1], zn[0], 32'h100 + 32'(t * 16 + zn), 0);
        idle(4);
      end
    end

    // stall held during redirect, branch presented mid-window
    step(1, 1, 1, 0, 32'h0000_3000, 0);
    step(1, 7, 0, 0, 32'h0000_4000, 1);
    step(1, 7, 0, 0, 32'h0000_4000, 1);
    step(1, 7, 0, 0, 32'h0000_4000, 1);
    step(0, 0, 0, 0, 32'h0, 0);
    step(1, 7, 0, 0, 32'h0000_5000, 0);
    idle(4);

    // branch arriving under stall evaluated once stall drops
    step(1, 7, 0, 0, 32'h0000_6000, 1);
    step(1, 7, 0, 0, 32'h0000_6000, 0);
    idle(4);

    // async reset in the middle of the flush window
    step(1, 1, 1, 0, 32'h0000_7000, 0);
    step(0, 0, 0, 0, 32'h0, 0);
    #2 Rst = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge Clk);
    #3 Rst = 1'b1;
    step(1, 7, 0, 0, 32'h0000_8000, 0);
    idle(4);

    // 20 taken jumps saturate the 4-bit counters on d1
    for (int k = 0; k < 20; k++) begin
      step(1, 7, 0, 0, 32'h9000 + 32'(k), 0);
      idle(3);
    end
    check("d1 sat branch_cnt", 64'(bc_w[1]), 64'd15);
    check("d1 sat taken_cnt", 64'(tc_w[1]), 64'd15);

    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           32'($urandom),
           ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
